// File: rtl/disp_timing_pkg.sv
// disp_timing_pkg: shared 640x480 raster timing constants, count width and RGB colors
// Used by display_timing and by the downstream block controller.
package disp_timing_pkg;
    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam int DISP_CLK_DIV     = 4;
    localparam int DISP_H_TOTAL     = 800;
    localparam int DISP_H_SYNC      = 96;
    localparam int DISP_H_ACT_START = 144;
    localparam int DISP_H_ACT_END   = 784;
    localparam int DISP_V_TOTAL     = 525;
    localparam int DISP_V_SYNC      = 2;
    localparam int DISP_V_ACT_START = 35;
    localparam int DISP_V_ACT_END   = 515;
    localparam logic [11:0] RGB_BLACK = 12'h000;
    localparam logic [11:0] RGB_WHITE = 12'hfff;
    localparam logic [11:0] RGB_RED   = 12'hf00;
    localparam logic [11:0] RGB_GREEN = 12'h0f0;
    localparam logic [11:0] RGB_BLUE  = 12'h00f;
    // Inclusive start, exclusive end.
    function automatic logic in_range(cnt_t x, cnt_t lo, cnt_t hi);
        return x >= lo && x < hi;
    endfunction
endpackage

// File: rtl/clk_en_div.sv
// clk_en_div: prescaler producing a one-cycle enable every DIV clocks
// Ports: clk system clock; rst_n async active-low reset; en strobe, high when
// the internal count reaches DIV-1 (constantly high when DIV = 1).
module clk_en_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic en
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt;
    assign en = cnt == W'(DIV - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= en ? '0 : cnt + W'(1);
endmodule

// File: rtl/display_timing.sv
// display_timing: VGA raster timing generator (pixel strobe, h/v counters, syncs, bright)
// Ports: clk system clock; rst async active-low reset; pix_en pixel strobe;
// hCount/vCount raster position; hSync/vSync active-low syncs; bright active video;
// frame_tick/frame_cnt frame pulse and counter, built only when DISP_FRAME_TICK_EN
// is defined and otherwise tied to 0.
module display_timing
    import disp_timing_pkg::*;
#(
    parameter int CLK_DIV     = DISP_CLK_DIV,
    parameter int H_TOTAL     = DISP_H_TOTAL,
    parameter int H_SYNC      = DISP_H_SYNC,
    parameter int H_ACT_START = DISP_H_ACT_START,
    parameter int H_ACT_END   = DISP_H_ACT_END,
    parameter int V_TOTAL     = DISP_V_TOTAL,
    parameter int V_SYNC      = DISP_V_SYNC,
    parameter int V_ACT_START = DISP_V_ACT_START,
    parameter int V_ACT_END   = DISP_V_ACT_END
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_en,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             hSync,
    output logic             vSync,
    output logic             bright,
    output logic             frame_tick,
    output logic [7:0]       frame_cnt
);
    logic h_wrap, v_wrap;
    cnt_t h_nxt, v_nxt;

    clk_en_div #(.DIV(CLK_DIV)) u_div (.clk(clk), .rst_n(rst), .en(pix_en));

    always_comb begin
        h_wrap = hCount == cnt_t'(H_TOTAL - 1);
        v_wrap = vCount == cnt_t'(V_TOTAL - 1);
        h_nxt  = h_wrap ? '0 : hCount + cnt_t'(1);
        v_nxt  = !h_wrap ? vCount : v_wrap ? '0 : vCount + cnt_t'(1);
    end

    // Syncs and bright are decoded from the next position so they change on the
    // same edge as the counters they describe.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            hCount <= '0;
            vCount <= '0;
            hSync  <= 1'b0;
            vSync  <= 1'b0;
            bright <= 1'b0;
        end else if (pix_en) begin
            hCount <= h_nxt;
            vCount <= v_nxt;
            hSync  <= h_nxt >= cnt_t'(H_SYNC);
            vSync  <= v_nxt >= cnt_t'(V_SYNC);
            bright <= in_range(h_nxt, cnt_t'(H_ACT_START), cnt_t'(H_ACT_END)) &&
                      in_range(v_nxt, cnt_t'(V_ACT_START), cnt_t'(V_ACT_END));
        end

`ifdef DISP_FRAME_TICK_EN
    logic frame_wrap;
    assign frame_wrap = pix_en && h_wrap && v_wrap;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_tick <= frame_wrap;
            if (frame_wrap) frame_cnt <= frame_cnt + 8'd1;
        end
`else
    assign frame_tick = 1'b0;
    assign frame_cnt  = '0;
`endif
endmodule
